// File: rtl/perceptron_n_comm_ctrl_if.sv
// rtl/perceptron_n_comm_ctrl_if.sv - UART byte link and perceptron register bus bundle
interface perceptron_n_comm_ctrl_if #(
  parameter int N_INPUTS   = 2,
  parameter int WORD_BYTES = 2
) ();
  localparam int WW = 8 * WORD_BYTES;

  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic [7:0]             tx_data;
  logic                   tx_start;
  logic                   tx_busy;
  logic [N_INPUTS*WW-1:0] weights;
  logic [N_INPUTS*WW-1:0] inputs;
  logic                   weights_load;
  logic                   inputs_load;
  logic [WW-1:0]          result;
  logic                   busy;

  modport slave (
    input  rx_data, rx_valid, tx_busy, result,
    output tx_data, tx_start, weights, inputs, weights_load, inputs_load, busy
  );

  modport master (
    output rx_data, rx_valid, tx_busy, result,
    input  tx_data, tx_start, weights, inputs, weights_load, inputs_load, busy
  );
endinterface

// File: rtl/perceptron_n_comm_ctrl.sv
// rtl/perceptron_n_comm_ctrl.sv - UART command decoder driving perceptron weight/input registers
module perceptron_n_comm_ctrl #(
  parameter int N_INPUTS       = 2,
  parameter int WORD_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input logic                  clk,
  input logic                  rst_n,
  perceptron_n_comm_ctrl_if.slave bus
);
  localparam int WW       = 8 * WORD_BYTES;
  localparam int PW       = N_INPUTS * WW;
  localparam int RESP_MAX = 1 + (N_INPUTS + 1) * WORD_BYTES;
  localparam int IW       = $clog2(RESP_MAX + 1);
  localparam int WCW      = $clog2(N_INPUTS + 1);
  localparam int BCW      = $clog2(WORD_BYTES + 1);
  localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int OW       = $clog2(PW);

  localparam logic [7:0] OP_READ        = 8'd5;
  localparam logic [7:0] OP_WR_WEIGHTS  = 8'd50;
  localparam logic [7:0] OP_WR_INPUTS   = 8'd51;
  localparam logic [7:0] OP_READ_PARAMS = 8'd52;
  localparam logic [7:0] RSP_READ       = 8'd100;
  localparam logic [7:0] RSP_OK         = 8'd101;
  localparam logic [7:0] RSP_ERR        = 8'd102;

  typedef enum logic [2:0] {IDLE, RX_PAYLOAD, TX_LOAD, TX_WAIT_BUSY, TX_WAIT_IDLE} state_t;

  state_t           state;
  logic [PW-1:0]    weights_q;
  logic [PW-1:0]    inputs_q;
  logic [PW-1:0]    shadow;
  logic             target_inputs;
  logic             commit_pending;
  logic [WCW-1:0]   wcnt;
  logic [BCW-1:0]   bcnt;
  logic [TW-1:0]    timer;
  logic [7:0]       resp [RESP_MAX];
  logic [IW-1:0]    resp_len;
  logic [IW-1:0]    tx_idx;
  logic [7:0]       tx_data_q;
  logic             tx_start_q;
  logic             weights_load_q;
  logic             inputs_load_q;
  logic [OW-1:0]    off;
  logic             last_byte;

  // Bit position of the incoming payload byte: word wcnt, MSB-first within the word
  always_comb begin
    off       = OW'(int'(wcnt) * WW + (WORD_BYTES - 1 - int'(bcnt)) * 8);
    last_byte = (wcnt == WCW'(N_INPUTS - 1)) && (bcnt == BCW'(WORD_BYTES - 1));
  end

  // Command FSM: decode, payload capture with timeout, commit, byte-wise transmit handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      weights_q      <= '0;
      inputs_q       <= '0;
      shadow         <= '0;
      target_inputs  <= 1'b0;
      commit_pending <= 1'b0;
      wcnt           <= '0;
      bcnt           <= '0;
      timer          <= '0;
      resp_len       <= '0;
      tx_idx         <= '0;
      tx_data_q      <= '0;
      tx_start_q     <= 1'b0;
      weights_load_q <= 1'b0;
      inputs_load_q  <= 1'b0;
      for (int i = 0; i < RESP_MAX; i++) resp[i] <= '0;
    end else begin
      weights_load_q <= 1'b0;
      inputs_load_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            tx_idx <= '0;
            case (bus.rx_data)
              OP_READ: begin
                // Snapshot taken now so later register changes cannot tear the response
                resp[0] <= RSP_READ;
                for (int k = 0; k < N_INPUTS; k++)
                  for (int b = 0; b < WORD_BYTES; b++)
                    resp[1 + k*WORD_BYTES + b] <= weights_q[k*WW + (WORD_BYTES-1-b)*8 +: 8];
                for (int b = 0; b < WORD_BYTES; b++)
                  resp[1 + N_INPUTS*WORD_BYTES + b] <= bus.result[(WORD_BYTES-1-b)*8 +: 8];
                resp_len <= IW'(RESP_MAX);
                state    <= TX_LOAD;
              end
              OP_READ_PARAMS: begin
                resp[0]  <= RSP_READ;
                resp[1]  <= 8'(N_INPUTS);
                resp[2]  <= 8'(WORD_BYTES);
                resp_len <= IW'(3);
                state    <= TX_LOAD;
              end
              OP_WR_WEIGHTS, OP_WR_INPUTS: begin
                target_inputs  <= (bus.rx_data == OP_WR_INPUTS);
                commit_pending <= 1'b0;
                wcnt           <= '0;
                bcnt           <= '0;
                timer          <= '0;
                state          <= RX_PAYLOAD;
              end
              default: begin
                resp[0]  <= RSP_ERR;
                resp_len <= IW'(1);
                state    <= TX_LOAD;
              end
            endcase
          end
        end
        RX_PAYLOAD: begin
          if (commit_pending) begin
            // Whole payload present: publish it in one cycle
            if (target_inputs) begin
              inputs_q      <= shadow;
              inputs_load_q <= 1'b1;
            end else begin
              weights_q      <= shadow;
              weights_load_q <= 1'b1;
            end
            commit_pending <= 1'b0;
            resp[0]        <= RSP_OK;
            resp_len       <= IW'(1);
            tx_idx         <= '0;
            state          <= TX_LOAD;
          end else if (bus.rx_valid) begin
            // A byte on the expiry cycle wins over the timeout
            shadow[off +: 8] <= bus.rx_data;
            timer            <= '0;
            if (last_byte) begin
              commit_pending <= 1'b1;
            end else if (bcnt == BCW'(WORD_BYTES - 1)) begin
              bcnt <= '0;
              wcnt <= wcnt + WCW'(1);
            end else begin
              bcnt <= bcnt + BCW'(1);
            end
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            resp[0]  <= RSP_ERR;
            resp_len <= IW'(1);
            tx_idx   <= '0;
            state    <= TX_LOAD;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        TX_LOAD: begin
          tx_data_q  <= resp[tx_idx];
          tx_start_q <= 1'b1;
          state      <= TX_WAIT_BUSY;
        end
        TX_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            tx_start_q <= 1'b0;
            state      <= TX_WAIT_IDLE;
          end
        end
        TX_WAIT_IDLE: begin
          if (!bus.tx_busy) begin
            if (tx_idx == resp_len - IW'(1)) begin
              state <= IDLE;
            end else begin
              tx_idx <= tx_idx + IW'(1);
              state  <= TX_LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_data      = tx_data_q;
  assign bus.tx_start     = tx_start_q;
  assign bus.weights      = weights_q;
  assign bus.inputs       = inputs_q;
  assign bus.weights_load = weights_load_q;
  assign bus.inputs_load  = inputs_load_q;
  assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_perceptron_n_comm_ctrl.sv
// tb/tb_perceptron_n_comm_ctrl.sv - randomized bench with behavioural command model for two configurations
module tb_perceptron_n_comm_ctrl;
  localparam int T = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  rxd [2];
  logic        rxv [2];
  logic        txb [2];
  logic [15:0] res [2];

  perceptron_n_comm_ctrl_if #(.N_INPUTS(2), .WORD_BYTES(2)) ifa ();
  perceptron_n_comm_ctrl_if #(.N_INPUTS(4), .WORD_BYTES(1)) ifb ();

  assign ifa.rx_data  = rxd[0];
  assign ifa.rx_valid = rxv[0];
  assign ifa.tx_busy  = txb[0];
  assign ifa.result   = res[0];
  assign ifb.rx_data  = rxd[1];
  assign ifb.rx_valid = rxv[1];
  assign ifb.tx_busy  = txb[1];
  assign ifb.result   = res[1][7:0];

  perceptron_n_comm_ctrl #(.N_INPUTS(2), .WORD_BYTES(2), .TIMEOUT_CYCLES(T)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  perceptron_n_comm_ctrl #(.N_INPUTS(4), .WORD_BYTES(1), .TIMEOUT_CYCLES(T)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  logic [31:0] w_s [2], i_s [2];
  logic        wl_s [2], il_s [2], bz_s [2], ts_s [2];
  logic [7:0]  td_s [2];
  assign w_s[0] = ifa.weights;       assign w_s[1] = ifb.weights;
  assign i_s[0] = ifa.inputs;        assign i_s[1] = ifb.inputs;
  assign wl_s[0] = ifa.weights_load; assign wl_s[1] = ifb.weights_load;
  assign il_s[0] = ifa.inputs_load;  assign il_s[1] = ifb.inputs_load;
  assign bz_s[0] = ifa.busy;         assign bz_s[1] = ifb.busy;
  assign ts_s[0] = ifa.tx_start;     assign ts_s[1] = ifb.tx_start;
  assign td_s[0] = ifa.tx_data;      assign td_s[1] = ifb.tx_data;

  // model state
  logic [31:0] exp_w [2], exp_i [2];
  logic        exp_wl [2], exp_il [2];
  logic [7:0]  got0 [$], got1 [$], expq [$];
  logic [7:0]  pl [8];
  int          gp [8];
  int          vectors = 0, miscompares = 0;

  function automatic int n_of(input int d);  return (d == 0) ? 2 : 4; endfunction
  function automatic int wb_of(input int d); return (d == 0) ? 2 : 1; endfunction
  function automatic int got_size(input int d); return (d == 0) ? got0.size() : got1.size(); endfunction
  function automatic logic [7:0] got_at(input int d, input int i); return (d == 0) ? got0[i] : got1[i]; endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, want, $time);
    end
  endtask

  // per-cycle register and load-pulse check against the model
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int d = 0; d < 2; d++) begin
        chk("weights", d, w_s[d], exp_w[d]);
        chk("inputs", d, i_s[d], exp_i[d]);
        chk("weights_load", d, {31'b0, wl_s[d]}, {31'b0, exp_wl[d]});
        chk("inputs_load", d, {31'b0, il_s[d]}, {31'b0, exp_il[d]});
      end
    end
  end

  // UART transmitter model: captures each requested byte, random latency and busy length
  task automatic tx_model(input int d);
    logic [7:0] cap;
    txb[d] = 1'b0;
    forever begin
      @(negedge clk);
      if (ts_s[d] && !txb[d]) begin
        cap = td_s[d];
        if (d == 0) got0.push_back(cap); else got1.push_back(cap);
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          if (ts_s[d]) chk("tx_data_stable", d, {24'b0, td_s[d]}, {24'b0, cap});
        end
        txb[d] = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        txb[d] = 1'b0;
      end
    end
  endtask

  initial tx_model(0);
  initial tx_model(1);

  task automatic send_byte(input int d, input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rxd[d] = b;
    rxv[d] = 1'b1;
    @(negedge clk);
    rxv[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input bit inject);
    int n;
    for (n = 0; n < 3000; n++) begin
      rxv[d] = 1'b0;
      if (!bz_s[d]) break;
      if (inject && $urandom_range(0, 3) == 0) begin
        rxd[d] = 8'($urandom);
        rxv[d] = 1'b1;
      end
      @(negedge clk);
    end
    if (n == 3000) chk("busy_bound", d, {31'b0, bz_s[d]}, 32'd0);
  endtask

  task automatic check_resp(input int d, input string name);
    int n;
    n = got_size(d);
    chk({name, "_len"}, d, n, expq.size());
    for (int i = 0; i < n && i < expq.size(); i++)
      chk(name, d, {24'b0, got_at(d, i)}, {24'b0, expq[i]});
    got0.delete();
    got1.delete();
  endtask

  task automatic do_read(input int d);
    logic [31:0] t;
    int ww;
    ww = 8 * wb_of(d);
    expq = {8'd100};
    for (int k = 0; k < n_of(d); k++)
      for (int b = 0; b < wb_of(d); b++) begin
        t = exp_w[d] >> (k * ww + (wb_of(d) - 1 - b) * 8);
        expq.push_back(t[7:0]);
      end
    for (int b = 0; b < wb_of(d); b++) begin
      t = {16'b0, res[d]} >> ((wb_of(d) - 1 - b) * 8);
      expq.push_back(t[7:0]);
    end
    send_byte(d, 8'd5, 0);
    wait_idle(d, 1'b1);
    check_resp(d, "read");
  endtask

  // sends opcode and up to nbytes payload bytes; a gap of T or more means the timeout wins
  task automatic do_write(input int d, input logic [7:0] op, input int nbytes);
    int nb, sent;
    logic [31:0] val, word;
    nb = n_of(d) * wb_of(d);
    sent = 0;
    send_byte(d, op, 0);
    for (int i = 0; i < nbytes; i++) begin
      if (gp[i] >= T) break;
      send_byte(d, pl[i], gp[i]);
      sent++;
    end
    if (sent == nb) begin
      val = 0;
      for (int k = 0; k < n_of(d); k++) begin
        word = 0;
        for (int b = 0; b < wb_of(d); b++) word = (word << 8) | {24'b0, pl[k*wb_of(d) + b]};
        val = val | (word << (k * 8 * wb_of(d)));
      end
      if (op == 8'd50) begin exp_w[d] = val; exp_wl[d] = 1'b1; end
      else begin exp_i[d] = val; exp_il[d] = 1'b1; end
      @(negedge clk);
      exp_wl[d] = 1'b0;
      exp_il[d] = 1'b0;
      expq = {8'd101};
      wait_idle(d, 1'b1);
    end else begin
      expq = {8'd102};
      wait_idle(d, 1'b0);
    end
    check_resp(d, "write");
  endtask

  task automatic do_simple(input int d, input logic [7:0] op);
    if (op == 8'd52) expq = {8'd100, 8'(n_of(d)), 8'(wb_of(d))};
    else expq = {8'd102};
    send_byte(d, op, 0);
    wait_idle(d, 1'b1);
    check_resp(d, (op == 8'd52) ? "params" : "bad_op");
  endtask

  task automatic set_payload(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    pl[0] = b0; pl[1] = b1; pl[2] = b2; pl[3] = b3;
    for (int i = 0; i < 8; i++) gp[i] = 0;
  endtask

  initial begin
    int d, sel, nb, cnt, wait_n;
    logic [7:0] op;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rxd[i] = 0; rxv[i] = 0; res[i] = 0;
      exp_w[i] = 0; exp_i[i] = 0; exp_wl[i] = 0; exp_il[i] = 0;
    end
    for (int i = 0; i < 8; i++) begin pl[i] = 0; gp[i] = 0; end
    repeat (3) @(negedge clk);
    chk("reset_busy", 0, {31'b0, bz_s[0]}, 32'd0);
    chk("reset_tx_start", 0, {31'b0, ts_s[0]}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // defaults read back, literal pin
    res[0] = 16'd1;
    send_byte(0, 8'd5, 0);
    expq = {8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    wait_idle(0, 1'b1);
    check_resp(0, "read_default");

    // weights write and read back
    set_payload(8'h15, 8'hAA, 8'hFC, 8'h33);
    do_write(0, 8'd50, 4);
    chk("weights_lit", 0, w_s[0], 32'hFC33_15AA);
    res[0] = 16'hBEEF;
    send_byte(0, 8'd5, 0);
    expq = {8'd100, 8'h15, 8'hAA, 8'hFC, 8'h33, 8'hBE, 8'hEF};
    wait_idle(0, 1'b1);
    check_resp(0, "read_lit");

    // inputs write: word1 = 0x200F lands in the upper half
    set_payload(8'hE0, 8'h00, 8'h20, 8'h0F);
    do_write(0, 8'd51, 4);
    chk("inputs_lit", 0, i_s[0], 32'h200F_E000);

    // truncated write times out
    set_payload(8'h11, 8'h22, 8'h00, 8'h00);
    do_write(0, 8'd50, 2);
    chk("weights_kept", 0, w_s[0], 32'hFC33_15AA);

    // gap boundary: T-1 idle cycles still accepted, T idle cycles aborts
    set_payload(8'h01, 8'h02, 8'h03, 8'h04);
    gp[2] = T - 1;
    do_write(0, 8'd50, 4);
    set_payload(8'h05, 8'h06, 8'h07, 8'h08);
    gp[1] = T;
    do_write(0, 8'd50, 4);

    do_simple(0, 8'h07);
    do_simple(0, 8'd52);
    do_simple(1, 8'd52);
    set_payload(8'h9A, 8'h01, 8'h7F, 8'hC3);
    do_write(1, 8'd50, 4);
    chk("weights_b_lit", 1, w_s[1], 32'hC37F_019A);
    res[1] = 16'h005A;
    do_read(1);

    // reset during the third byte of a READ response
    res[0] = 16'h1234;
    send_byte(0, 8'd5, 0);
    for (wait_n = 0; wait_n < 2000 && got0.size() < 3; wait_n++) @(negedge clk);
    if (wait_n == 2000) chk("rst_wait", 0, got0.size(), 3);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin exp_w[i] = 0; exp_i[i] = 0; end
    #1;
    chk("rst_tx_start", 0, {31'b0, ts_s[0]}, 32'd0);
    chk("rst_tx_data", 0, {24'b0, td_s[0]}, 32'd0);
    chk("rst_weights", 0, w_s[0], 32'd0);
    chk("rst_busy", 0, {31'b0, bz_s[0]}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    got0.delete();
    got1.delete();
    do_read(0);

    // randomized traffic on both configurations
    for (int it = 0; it < 60; it++) begin
      d = $urandom_range(0, 1);
      sel = $urandom_range(0, 5);
      res[d] = 16'($urandom);
      nb = n_of(d) * wb_of(d);
      case (sel)
        0, 1: do_read(d);
        2, 3: begin
          for (int i = 0; i < 8; i++) begin
            pl[i] = 8'($urandom);
            gp[i] = ($urandom_range(0, 9) == 0) ? T - 1 + $urandom_range(0, 1) : $urandom_range(0, 3);
          end
          cnt = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nb - 1) : nb;
          do_write(d, (sel == 2) ? 8'd50 : 8'd51, cnt);
        end
        4: do_simple(d, 8'd52);
        default: begin
          op = 8'($urandom);
          while (op == 8'd5 || op == 8'd50 || op == 8'd51 || op == 8'd52) op = 8'($urandom);
          do_simple(d, op);
        end
      endcase
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
